// File: rtl/instr_fetch_if.sv
// Fetcher-side bundle: sequencer start/hold, shared UART TX/RX strobes, fetched instruction.
interface instr_fetch_if;
   logic        start;
   logic        hold;
   logic [7:0]  address;
   logic        rx_done;
   logic [7:0]  rx_data;
   logic        tx_done;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic [15:0] instruction;
   logic        done;
   logic        busy;
   logic        error;

   modport master (
      output start, hold, address, rx_done, rx_data, tx_done,
      input  tx_start, tx_data, instruction, done, busy, error
   );

   modport slave (
      input  start, hold, address, rx_done, rx_data, tx_done,
      output tx_start, tx_data, instruction, done, busy, error
   );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// UART instruction fetcher: sends opcode + PC address, collects a 16-bit reply with timeout/retry.
// Optional FETCH_CHECKSUM_EN adds a third reply byte checked against hi^lo^address.
module instr_fetch_ctrl #(
   parameter logic [7:0]  REQ_OPCODE     = 8'h03,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd60000,
   parameter int unsigned MAX_RETRIES    = 2
) (
   input logic          clk,
   input logic          rst,
   instr_fetch_if.slave bus
);
   localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

   typedef enum logic [3:0] {
      IDLE, SEND_OP, WAIT_OP, SEND_ADDR, WAIT_ADDR, RECV_HI, RECV_LO,
`ifdef FETCH_CHECKSUM_EN
      RECV_CK,
`endif
      DONE
   } state_t;

   state_t          state;
   logic [7:0]      addr_q;
   logic [7:0]      hi_q;
`ifdef FETCH_CHECKSUM_EN
   logic [7:0]      lo_q;
`endif
   logic [15:0]     cnt;
   logic [RW-1:0]   retry;
   logic            tx_start_q;
   logic [7:0]      tx_data_q;
   logic [15:0]     instr_q;
   logic            done_q;
   logic            busy_q;
   logic            error_q;

   logic            in_recv;
   logic            ck_bad;
   logic            fail;

   // A byte arriving on the last counted cycle takes priority over expiry.
   always_comb begin
      in_recv = (state == RECV_HI) || (state == RECV_LO);
      ck_bad  = 1'b0;
`ifdef FETCH_CHECKSUM_EN
      in_recv = in_recv || (state == RECV_CK);
      ck_bad  = (state == RECV_CK) && bus.rx_done &&
                (bus.rx_data != (hi_q ^ lo_q ^ addr_q));
`endif
      fail = (in_recv && !bus.rx_done && (cnt <= 16'd1)) || ck_bad;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         addr_q     <= '0;
         hi_q       <= '0;
`ifdef FETCH_CHECKSUM_EN
         lo_q       <= '0;
`endif
         cnt        <= '0;
         retry      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         instr_q    <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         done_q     <= 1'b0;
         if (fail) begin
            if (retry < RW'(MAX_RETRIES)) begin
               retry     <= retry + 1'b1;
               hi_q      <= '0;
               tx_data_q <= REQ_OPCODE;
               state     <= SEND_OP;
            end else begin
               error_q <= 1'b1;
               busy_q  <= 1'b0;
               state   <= IDLE;
            end
         end else begin
            case (state)
               IDLE: if (bus.start && !bus.hold) begin
                  addr_q    <= bus.address;
                  error_q   <= 1'b0;
                  retry     <= '0;
                  busy_q    <= 1'b1;
                  tx_data_q <= REQ_OPCODE;
                  state     <= SEND_OP;
               end
               SEND_OP: if (!bus.hold) begin
                  tx_start_q <= 1'b1;
                  state      <= WAIT_OP;
               end
               WAIT_OP: if (bus.tx_done) begin
                  tx_data_q <= addr_q;
                  state     <= SEND_ADDR;
               end
               SEND_ADDR: if (!bus.hold) begin
                  tx_start_q <= 1'b1;
                  state      <= WAIT_ADDR;
               end
               WAIT_ADDR: if (bus.tx_done) begin
                  cnt   <= TIMEOUT_CYCLES;
                  state <= RECV_HI;
               end
               RECV_HI: if (bus.rx_done) begin
                  hi_q  <= bus.rx_data;
                  cnt   <= TIMEOUT_CYCLES;
                  state <= RECV_LO;
               end else begin
                  cnt <= cnt - 16'd1;
               end
               RECV_LO: if (bus.rx_done) begin
`ifdef FETCH_CHECKSUM_EN
                  lo_q  <= bus.rx_data;
                  cnt   <= TIMEOUT_CYCLES;
                  state <= RECV_CK;
`else
                  instr_q <= {hi_q, bus.rx_data};
                  done_q  <= 1'b1;
                  state   <= DONE;
`endif
               end else begin
                  cnt <= cnt - 16'd1;
               end
`ifdef FETCH_CHECKSUM_EN
               // Mismatch is routed through fail, so reaching here with rx_done means a match.
               RECV_CK: if (bus.rx_done) begin
                  instr_q <= {hi_q, lo_q};
                  done_q  <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt - 16'd1;
               end
`endif
               DONE: begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.tx_start    = tx_start_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.instruction = instr_q;
   assign bus.done        = done_q;
   assign bus.busy        = busy_q;
   assign bus.error       = error_q;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized bench for instr_fetch_ctrl: emulated UART host plus a transaction-level expectation model.
module tb_instr_fetch_ctrl;
   localparam logic [7:0]  OPC     = 8'h03;
   localparam logic [15:0] TO      = 16'd40;
   localparam int          RETRIES = 2;

   logic clk = 1'b0;
   logic rst;
   instr_fetch_if ifc();

   instr_fetch_ctrl #(.REQ_OPCODE(OPC), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(RETRIES)) dut (
      .clk(clk), .rst(rst), .bus(ifc)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          done_cnt = 0;
   int          bad_chg  = 0;
   logic [7:0]  tx_log[$];
   logic [15:0] prev_instr = '0;
   logic [15:0] exp_instr  = '0;

   // Observes the UART TX stream, done pulses and any instruction change not accompanied by done.
   always @(negedge clk) begin
      if (ifc.tx_start === 1'b1) tx_log.push_back(ifc.tx_data);
      if (ifc.done === 1'b1) done_cnt++;
      if (rst === 1'b0 && ifc.done !== 1'b1 && ifc.instruction !== prev_instr) bad_chg++;
      prev_instr = ifc.instruction;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic hold_window(input string nm);
      int h;
      bit seen;
      h = $urandom_range(5, 1);
      seen = 1'b0;
      ifc.hold = 1'b1;
      repeat (h) begin
         cyc();
         if (ifc.tx_start === 1'b1) seen = 1'b1;
      end
      ifc.hold = 1'b0;
      n_checks++;
      if (seen !== 1'b0) $display("FAIL %s: tx_start seen while hold high", nm);
      else n_pass++;
   endtask

   task automatic do_start(input logic [7:0] addr, input bit do_hold);
      ifc.address = addr;
      ifc.start   = 1'b1;
      cyc();
      ifc.start   = 1'b0;
      if (do_hold) hold_window("hold_op");
   endtask

   task automatic pulse_tx_done(input bit do_hold);
      cyc($urandom_range(3, 0));
      ifc.tx_done = 1'b1;
      cyc();
      ifc.tx_done = 1'b0;
      if (do_hold) hold_window("hold_addr");
   endtask

   task automatic expect_byte(input logic [7:0] want, input string nm);
      logic [7:0] b;
      bit got;
      b = 'x;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         cyc();
         if (ifc.tx_start === 1'b1) begin
            got = 1'b1;
            b = ifc.tx_data;
         end
      end
      n_checks++;
      if (!got || b !== want) $display("FAIL %s: tx byte got %h (seen=%0d) want %h", nm, b, got, want);
      else n_pass++;
   endtask

   task automatic serve_request(input logic [7:0] addr, input bit do_hold);
      expect_byte(OPC, "op_byte");
      pulse_tx_done(do_hold);
      expect_byte(addr, "addr_byte");
      pulse_tx_done(do_hold);
   endtask

   task automatic send_rx(input logic [7:0] v, input int dly);
      cyc(dly);
      ifc.rx_data = v;
      ifc.rx_done = 1'b1;
      cyc();
      ifc.rx_done = 1'b0;
      ifc.rx_data = 8'($urandom);
   endtask

   task automatic send_reply(input logic [7:0] addr, input logic [7:0] hi, input logic [7:0] lo, input int dly);
      send_rx(hi, dly);
      send_rx(lo, dly);
`ifdef FETCH_CHECKSUM_EN
      send_rx(hi ^ lo ^ addr, dly);
`else
      if (addr === 8'hxx) cyc();
`endif
   endtask

   task automatic finish_fetch(input logic [15:0] want, input int d0, input int n_tx, input string nm);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         if (ifc.done === 1'b1) got = 1'b1;
         else cyc();
      end
      n_checks++;
      if (!got || ifc.instruction !== want)
         $display("FAIL %s instr: got %h (done=%0d) want %h", nm, ifc.instruction, got, want);
      else n_pass++;
      n_checks++;
      if (ifc.busy !== 1'b1 || ifc.error !== 1'b0)
         $display("FAIL %s flags at done: busy=%b error=%b want busy=1 error=0", nm, ifc.busy, ifc.error);
      else n_pass++;
      cyc();
      n_checks++;
      if (ifc.busy !== 1'b0 || ifc.done !== 1'b0)
         $display("FAIL %s after done: busy=%b done=%b want 0 0", nm, ifc.busy, ifc.done);
      else n_pass++;
      cyc();
      n_checks++;
      if (done_cnt !== d0 + 1 || tx_log.size() !== n_tx)
         $display("FAIL %s counts: done pulses %0d tx bytes %0d want %0d %0d", nm, done_cnt - d0, tx_log.size(), 1, n_tx);
      else n_pass++;
   endtask

   task automatic run_fetch(input logic [7:0] addr, input logic [7:0] hi, input logic [7:0] lo,
                            input bit do_hold, input bit stray);
      int d0;
      d0 = done_cnt;
      tx_log.delete();
      do_start(addr, do_hold);
      serve_request(addr, do_hold);
      if (stray) begin
         ifc.address = ~addr;
         ifc.start = 1'b1;
         cyc();
         ifc.start = 1'b0;
         ifc.address = addr;
      end
      send_reply(addr, hi, lo, $urandom_range(6, 0));
      exp_instr = {hi, lo};
      finish_fetch(exp_instr, d0, 2, "fetch");
   endtask

   task automatic test_reset;
      rst = 1'b1;
      ifc.start = 1'b0; ifc.hold = 1'b0; ifc.address = '0;
      ifc.rx_done = 1'b0; ifc.rx_data = '0; ifc.tx_done = 1'b0;
      cyc(3);
      n_checks++;
      if ({ifc.tx_start, ifc.tx_data, ifc.instruction, ifc.done, ifc.busy, ifc.error} !== 28'd0)
         $display("FAIL reset_state: tx_start=%b tx_data=%h instr=%h done=%b busy=%b error=%b want all 0",
                  ifc.tx_start, ifc.tx_data, ifc.instruction, ifc.done, ifc.busy, ifc.error);
      else n_pass++;
      rst = 1'b0;
      cyc(3);
      n_checks++;
      if (ifc.busy !== 1'b0 || ifc.tx_start !== 1'b0)
         $display("FAIL post_reset_idle: busy=%b tx_start=%b want 0 0", ifc.busy, ifc.tx_start);
      else n_pass++;
   endtask

   task automatic test_basic;
      run_fetch(8'h05, 8'h12, 8'h34, 1'b0, 1'b0);
   endtask

   task automatic test_hold_start;
      tx_log.delete();
      ifc.hold = 1'b1;
      ifc.address = 8'($urandom);
      ifc.start = 1'b1;
      cyc();
      ifc.start = 1'b0;
      cyc(5);
      ifc.hold = 1'b0;
      cyc(5);
      n_checks++;
      if (ifc.busy !== 1'b0 || tx_log.size() !== 0)
         $display("FAIL hold_start_ignored: busy=%b tx bytes=%0d want 0 0", ifc.busy, tx_log.size());
      else n_pass++;
      run_fetch(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 8; i++)
         run_fetch(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic test_rx_deadline;
      logic [7:0] addr, hi, lo;
      int d0;
      addr = 8'($urandom); hi = 8'($urandom); lo = 8'($urandom);
      d0 = done_cnt;
      tx_log.delete();
      do_start(addr, 1'b0);
      serve_request(addr, 1'b0);
      send_reply(addr, hi, lo, int'(TO) - 1);
      exp_instr = {hi, lo};
      finish_fetch(exp_instr, d0, 2, "deadline");
   endtask

   task automatic test_timeout_retry;
      logic [7:0] addr;
      int d0, c;
      bit got;
      addr = 8'($urandom);
      d0 = done_cnt;
      tx_log.delete();
      do_start(addr, 1'b0);
      serve_request(addr, 1'b0);
      got = 1'b0;
      c = 0;
      while (!got && c < 200) begin
         cyc();
         c++;
         if (ifc.tx_start === 1'b1) got = 1'b1;
      end
      n_checks++;
      if (!got || c < int'(TO) || c > int'(TO) + 2)
         $display("FAIL retry_gap: resend after %0d cycles (seen=%0d) want %0d..%0d", c, got, int'(TO), int'(TO) + 2);
      else n_pass++;
      n_checks++;
      if (ifc.tx_data !== OPC) $display("FAIL retry_op: got %h want %h", ifc.tx_data, OPC);
      else n_pass++;
      pulse_tx_done(1'b0);
      expect_byte(addr, "retry_addr");
      pulse_tx_done(1'b0);
      send_reply(addr, 8'hAB, 8'hCD, 3);
      exp_instr = 16'hABCD;
      finish_fetch(exp_instr, d0, 4, "retry");
   endtask

   task automatic test_exhaust;
      logic [7:0] addr;
      int d0;
      addr = 8'($urandom);
      d0 = done_cnt;
      tx_log.delete();
      do_start(addr, 1'b0);
      for (int a = 0; a <= RETRIES; a++) serve_request(addr, 1'b0);
      cyc(2 * int'(TO) + 10);
      n_checks++;
      if (ifc.error !== 1'b1 || ifc.busy !== 1'b0)
         $display("FAIL exhaust_flags: error=%b busy=%b want 1 0", ifc.error, ifc.busy);
      else n_pass++;
      n_checks++;
      if (ifc.instruction !== exp_instr || done_cnt !== d0)
         $display("FAIL exhaust_keep: instr=%h done pulses=%0d want %h 0", ifc.instruction, done_cnt - d0, exp_instr);
      else n_pass++;
      n_checks++;
      if (tx_log.size() !== 2 * (RETRIES + 1))
         $display("FAIL exhaust_requests: tx bytes %0d want %0d", tx_log.size(), 2 * (RETRIES + 1));
      else n_pass++;
      // A new fetch must clear the sticky error flag.
      run_fetch(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid;
      int d0;
      d0 = done_cnt;
      tx_log.delete();
      do_start(8'h44, 1'b0);
      serve_request(8'h44, 1'b0);
      send_rx(8'h99, 2);
      cyc(2);
      rst = 1'b1;
      cyc(2);
      n_checks++;
      if ({ifc.instruction, ifc.busy, ifc.done, ifc.error, ifc.tx_start} !== 20'd0)
         $display("FAIL reset_mid: instr=%h busy=%b done=%b error=%b tx_start=%b want all 0",
                  ifc.instruction, ifc.busy, ifc.done, ifc.error, ifc.tx_start);
      else n_pass++;
      rst = 1'b0;
      cyc(3);
      n_checks++;
      if (done_cnt !== d0) $display("FAIL reset_mid_done: %0d done pulses want 0", done_cnt - d0);
      else n_pass++;
      exp_instr = 16'h0000;
      run_fetch(8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
   endtask

`ifdef FETCH_CHECKSUM_EN
   task automatic test_checksum;
      int d0;
      run_fetch(8'h02, 8'h10, 8'h20, 1'b0, 1'b0);
      d0 = done_cnt;
      tx_log.delete();
      do_start(8'h02, 1'b0);
      serve_request(8'h02, 1'b0);
      send_rx(8'h10, 1);
      send_rx(8'h20, 1);
      send_rx(8'h33, 1);
      serve_request(8'h02, 1'b0);
      send_rx(8'h10, 1);
      send_rx(8'h20, 1);
      send_rx(8'h32, 1);
      exp_instr = 16'h1020;
      finish_fetch(exp_instr, d0, 4, "checksum_retry");
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_hold_start();
      test_random();
      test_rx_deadline();
      test_timeout_retry();
      test_exhaust();
      test_reset_mid();
`ifdef FETCH_CHECKSUM_EN
      test_checksum();
`endif
      n_checks++;
      if (bad_chg !== 0) $display("FAIL partial_instr: %0d changes without done, want 0", bad_chg);
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
